pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Stall/flush controller that drives the PC hold input and the pipeline-register hold/flush controls.
//  Sits beside the 5-stage datapath. It detects load-use hazards in ID, taken branches resolved in EX,
//  jumps decoded in ID, and data-memory wait states in MEM.
//  o_pc_hold=1 freezes the PC register (the PC loads its next value only when o_pc_hold=0).
// PARAMETERS
//  REG_AW        5   register-index width
//  FLUSH_CYCLES  1   wrong-path cycles flushed after a taken branch, 1..3
//  CNT_W         32  width of stall counter (only with HAZ_STALL_CNT_EN)
// PORTS
//  clk              in   1       clock, rising edge
//  reset            in   1       asynchronous, active-high
//  i_id_rs          in   REG_AW  rs index of instruction in ID
//  i_id_rt          in   REG_AW  rt index of instruction in ID
//  i_id_uses_rt     in   1       ID instruction reads rt
//  i_id_jump        in   1       jump decoded in ID (target known in ID)
//  i_ex_memread     in   1       instruction in EX is a load
//  i_ex_rd          in   REG_AW  destination of instruction in EX
//  i_ex_br_taken    in   1       branch in EX resolved taken
//  i_mem_req        in   1       MEM stage issues a data-memory access
//  i_mem_ready      in   1       data memory completes the access this cycle
//  o_pc_hold        out  1       1 = PC keeps its value
//  o_ifid_hold      out  1       1 = IF/ID register keeps its value
//  o_ifid_flush     out  1       1 = IF/ID loads a NOP
//  o_idex_flush     out  1       1 = ID/EX loads a bubble
//  o_exmem_hold     out  1       1 = EX/MEM and MEM/WB keep their values
//  o_stall_cnt      out  CNT_W   count of cycles with o_pc_hold=1 (HAZ_STALL_CNT_EN only)
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, REDIRECT. Reset -> RUN, flush counter 0, all outputs 0.
//    The reset value of o_stall_cnt is 0.
//  - Outputs are combinational from the current state and inputs; state updates on the clk rising edge.
//  - Load-use: lu = i_ex_memread & i_ex_rd!=0 & (i_ex_rd==i_id_rs | (i_id_uses_rt & i_ex_rd==i_id_rt)).
//  - Priority per cycle: memory wait > branch > load-use > jump.
//  - RUN:
//    - i_mem_req & !i_mem_ready: assert pc_hold, ifid_hold, exmem_hold; no flush; next state MEM_WAIT.
//    - else i_ex_br_taken: assert ifid_flush and idex_flush; pc_hold=0 (branch target loads);
//      next state REDIRECT with counter = FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in RUN.
//    - else lu: assert pc_hold and ifid_hold; idex_flush=1 (one bubble); stay in RUN.
//      The hazard clears next cycle because the load has moved to MEM.
//    - else i_id_jump: assert ifid_flush for 1 cycle; stay in RUN.
//  - MEM_WAIT:
//    - Hold pc, ifid, exmem; idex_flush=0; ignore branch, load-use and jump.
//    - On i_mem_ready=1: release all holds in that same cycle and return to RUN.
//    - A branch in EX is re-evaluated in RUN on the following cycle, since EX was frozen.
//  - REDIRECT:
//    - Assert ifid_flush each cycle; decrement the counter; return to RUN when the counter reaches 0.
//    - A memory wait arriving here takes priority: go to MEM_WAIT.
//      The remaining flush count is kept and resumed after MEM_WAIT.
//  - o_pc_hold and o_ifid_flush are never both 1.
//  - Reset asserted mid-stall: immediate return to RUN and all outputs 0.
// CONFIGURATION
//  - HAZ_STALL_CNT_EN defined: o_stall_cnt increments on every cycle with o_pc_hold=1.
//    It saturates at all-ones (no wrap) and clears on reset.
//  - Not defined: the o_stall_cnt port is absent and no counter logic is built.
// TESTING
//  - Load-use: EX lw rd=8, ID add rs=8 -> 1 cycle pc_hold=1, ifid_hold=1, idex_flush=1;
//    next cycle all 0.
//  - Load-use with rd=0, or rt match with i_id_uses_rt=0 -> no stall.
//  - Taken branch, FLUSH_CYCLES=2 -> ifid_flush=1 for 2 cycles, idex_flush=1 in first only,
//    pc_hold=0 throughout.
//  - mem_req with ready low for 3 cycles -> pc/ifid/exmem hold for exactly 3 cycles;
//    released in the cycle ready=1.
//  - Branch taken and mem wait in the same cycle -> MEM_WAIT first; flush occurs after ready.
//    Counter (if enabled) is +N for N wait cycles.
//  - Reset pulse during MEM_WAIT -> outputs 0 asynchronously; o_stall_cnt=0; state RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch redirect, jump and memory waits.
// Optional stall-cycle counter (o_stall_cnt) is built only when HAZ_STALL_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic              i_id_uses_rt,
   input  logic              i_id_jump,
   input  logic              i_ex_memread,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_ex_br_taken,
   input  logic              i_mem_req,
   input  logic              i_mem_ready,
   output logic              o_pc_hold,
   output logic              o_ifid_hold,
   output logic              o_ifid_flush,
   output logic              o_idex_flush,
   output logic              o_exmem_hold
`ifdef HAZ_STALL_CNT_EN
  ,output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

   state_t           r_state, w_nxt_state;
   logic [FCW-1:0]   r_cnt, w_nxt_cnt;
   logic             w_lu, w_mwait;

   assign w_lu    = i_ex_memread && (i_ex_rd != '0) &&
                    ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
   assign w_mwait = i_mem_req && !i_mem_ready;

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_cnt    = r_cnt;
      o_pc_hold    = 1'b0;
      o_ifid_hold  = 1'b0;
      o_ifid_flush = 1'b0;
      o_idex_flush = 1'b0;
      o_exmem_hold = 1'b0;
      // Outputs are forced quiet while reset is held, independent of the inputs.
      if (!reset) begin
         case (r_state)
            RUN: begin
               if (w_mwait) begin
                  o_pc_hold    = 1'b1;
                  o_ifid_hold  = 1'b1;
                  o_exmem_hold = 1'b1;
                  w_nxt_state  = MEM_WAIT;
               end else if (i_ex_br_taken) begin
                  o_ifid_flush = 1'b1;
                  o_idex_flush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     w_nxt_state = REDIRECT;
                     w_nxt_cnt   = FCW'(FLUSH_CYCLES - 1);
                  end
               end else if (w_lu) begin
                  o_pc_hold    = 1'b1;
                  o_ifid_hold  = 1'b1;
                  o_idex_flush = 1'b1;
               end else if (i_id_jump) begin
                  o_ifid_flush = 1'b1;
               end
            end
            MEM_WAIT: begin
               // A redirect interrupted by the wait resumes with its remaining count.
               if (i_mem_ready) begin
                  w_nxt_state = (r_cnt != '0) ? REDIRECT : RUN;
               end else begin
                  o_pc_hold    = 1'b1;
                  o_ifid_hold  = 1'b1;
                  o_exmem_hold = 1'b1;
               end
            end
            REDIRECT: begin
               if (w_mwait) begin
                  o_pc_hold    = 1'b1;
                  o_ifid_hold  = 1'b1;
                  o_exmem_hold = 1'b1;
                  w_nxt_state  = MEM_WAIT;
               end else begin
                  o_ifid_flush = 1'b1;
                  w_nxt_cnt    = r_cnt - FCW'(1);
                  if (r_cnt <= FCW'(1)) w_nxt_state = RUN;
               end
            end
            default: begin
               w_nxt_state = RUN;
               w_nxt_cnt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
      end
   end

`ifdef HAZ_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating: holds at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_stall_cnt <= '0;
      else if (o_pc_hold && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios with hand-written expectations, then randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
   localparam int AW = 5;
   localparam int FC = 2;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] id_rs, id_rt, ex_rd;
   logic          id_uses_rt, id_jump, ex_memread, ex_br_taken, mem_req, mem_ready;
   logic          pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold;
`ifdef HAZ_STALL_CNT_EN
   logic [CW-1:0] stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pipeline_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt), .i_id_jump(id_jump),
      .i_ex_memread(ex_memread), .i_ex_rd(ex_rd), .i_ex_br_taken(ex_br_taken),
      .i_mem_req(mem_req), .i_mem_ready(mem_ready),
      .o_pc_hold(pc_hold), .o_ifid_hold(ifid_hold), .o_ifid_flush(ifid_flush),
      .o_idex_flush(idex_flush), .o_exmem_hold(exmem_hold)
`ifdef HAZ_STALL_CNT_EN
     ,.o_stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // {pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold}
   wire [4:0] outv = {pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 0; id_jump = 0;
      ex_memread = 0; ex_br_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   // Called at a negedge with inputs already driven; checks, then advances one cycle.
   task automatic step(input string tag, input logic [4:0] exp);
      #1;
      chk(tag, outv, exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Behavioural model: a pending memory wait and a count of redirect cycles still owed.
   bit        m_wait;
   int        m_left;
   longint    m_cnt;
   logic [4:0] exp;

   initial begin
      reset = 1'b1;
      idle();
      #1;
      chk("reset_outs", outv, 5'b00000);
`ifdef HAZ_STALL_CNT_EN
      chk("reset_cnt", stall_cnt, 0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // Load-use on rs
      ex_memread = 1; ex_rd = 8; id_rs = 8;       step("lu_rs", 5'b11010);
      idle();                                     step("lu_clear", 5'b00000);
      // rd = 0 never stalls
      ex_memread = 1; ex_rd = 0; id_rs = 0;       step("lu_rd0", 5'b00000);
      // rt match only counts when rt is read
      ex_memread = 1; ex_rd = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0; step("lu_rt_unused", 5'b00000);
      id_uses_rt = 1;                             step("lu_rt_used", 5'b11010);
      idle();
      // Taken branch, two flush cycles
      ex_br_taken = 1;                            step("br_first", 5'b00110);
      ex_br_taken = 0;                            step("br_second", 5'b00100);
      step("br_done", 5'b00000);
      // Memory wait for three cycles
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++)                 step("mw_hold", 5'b11001);
      mem_ready = 1;                              step("mw_release", 5'b00000);
      idle();                                     step("mw_after", 5'b00000);
      // Branch and memory wait together: wait first, branch after
      mem_req = 1; mem_ready = 0; ex_br_taken = 1; step("brmw_hold", 5'b11001);
      mem_ready = 1;                              step("brmw_release", 5'b00000);
      mem_req = 0; mem_ready = 0;                 step("brmw_br", 5'b00110);
      ex_br_taken = 0;                            step("brmw_redir", 5'b00100);
      step("brmw_done", 5'b00000);
      // Redirect interrupted by a memory wait resumes afterwards
      ex_br_taken = 1;                            step("rdmw_br", 5'b00110);
      ex_br_taken = 0; mem_req = 1;               step("rdmw_hold1", 5'b11001);
      step("rdmw_hold2", 5'b11001);
      mem_ready = 1;                              step("rdmw_release", 5'b00000);
      mem_req = 0; mem_ready = 0;                 step("rdmw_resume", 5'b00100);
      step("rdmw_done", 5'b00000);
      // Jump, and load-use outranking jump
      id_jump = 1;                                step("jump", 5'b00100);
      ex_memread = 1; ex_rd = 3; id_rs = 3;       step("lu_over_jump", 5'b11010);
      idle();
      // Asynchronous reset in the middle of a memory wait
      mem_req = 1;                                step("rst_mw_enter", 5'b11001);
      #1;
      chk("rst_mw_pre", outv, 5'b11001);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_outs", outv, 5'b00000);
`ifdef HAZ_STALL_CNT_EN
      chk("rst_async_cnt", stall_cnt, 0);
`endif
      @(negedge clk);
      reset = 1'b0; idle(); id_jump = 1;          step("rst_back_in_run", 5'b00100);
      idle();

      // Randomized phase, model starts from a fresh reset
      reset = 1'b1; #1; reset = 1'b0;
      m_wait = 0; m_left = 0; m_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         bit rst_now, mw, lu;
         rst_now     = ($urandom_range(0, 199) == 0);
         id_rs       = AW'($urandom_range(0, 3));
         id_rt       = AW'($urandom_range(0, 3));
         ex_rd       = AW'($urandom_range(0, 3));
         id_uses_rt  = $urandom_range(0, 1) == 1;
         ex_memread  = $urandom_range(0, 1) == 1;
         id_jump     = $urandom_range(0, 3) == 0;
         ex_br_taken = $urandom_range(0, 5) == 0;
         mem_req     = $urandom_range(0, 2) == 0;
         mem_ready   = $urandom_range(0, 1) == 1;
         reset       = rst_now;
         mw = mem_req && !mem_ready;
         lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
         if (rst_now) begin
            m_wait = 0; m_left = 0; m_cnt = 0;
         end
         exp = 5'b00000;
         if (rst_now)          exp = 5'b00000;
         else if (m_wait)      exp = mem_ready ? 5'b00000 : 5'b11001;
         else if (mw)          exp = 5'b11001;
         else if (m_left > 0)  exp = 5'b00100;
         else if (ex_br_taken) exp = 5'b00110;
         else if (lu)          exp = 5'b11010;
         else if (id_jump)     exp = 5'b00100;
         #1;
         chk("rand_outs", outv, exp);
         chk("rand_excl", pc_hold & ifid_flush, 0);
`ifdef HAZ_STALL_CNT_EN
         chk("rand_cnt", stall_cnt, m_cnt[31:0]);
`endif
         @(posedge clk);
         if (!rst_now) begin
            if (exp[4] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_wait) begin
               if (mem_ready) m_wait = 0;
            end else if (mw) m_wait = 1;
            else if (m_left > 0) m_left--;
            else if (ex_br_taken) m_left = FC - 1;
         end
         @(negedge clk);
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
